// File: rtl/mc8051_mux_pipe_pkg.sv
// mc8051_mux_pipe_pkg: select encodings, S2 FSM states and register-bank address helpers
// for the registered operand/address mux.
`default_nettype none
package mc8051_mux_pipe_pkg;

  localparam logic [2:0] ALU_I0_ACC   = 3'd0;
  localparam logic [2:0] ALU_I0_BX    = 3'd1;
  localparam logic [2:0] ALU_I0_INSTR = 3'd2;
  localparam logic [2:0] ALU_I0_S2B   = 3'd3;
  localparam logic [2:0] ALU_I0_S3B   = 3'd4;
  localparam logic [2:0] ALU_I0_SX0   = 3'd5;
  localparam logic [2:0] ALU_I0_PSW   = 3'd6;

  localparam logic [2:0] ALU_I1_P1    = 3'd0;
  localparam logic [2:0] ALU_I1_M1    = 3'd1;
  localparam logic [2:0] ALU_I1_ZERO  = 3'd2;
  localparam logic [2:0] ALU_I1_BX    = 3'd3;
  localparam logic [2:0] ALU_I1_SX1   = 3'd4;
  localparam logic [2:0] ALU_I1_S2B   = 3'd5;
  localparam logic [2:0] ALU_I1_S3B   = 3'd6;

  localparam logic [3:0] S2_ADDR_RS0    = 4'd0;
  localparam logic [3:0] S2_ADDR_RI     = 4'd1;
  localparam logic [3:0] S2_ADDR_DIRECT = 4'd2;
  localparam logic [3:0] S2_ADDR_BITM   = 4'd3;
  localparam logic [3:0] S2_ADDR_SP     = 4'd4;
  localparam logic [3:0] S2_ADDR_DPTR   = 4'd5;
  localparam logic [3:0] S2_ADDR_PC     = 4'd6;
  localparam logic [3:0] S2_ADDR_DPTRPA = 4'd7;
  localparam logic [3:0] S2_ADDR_PCPA   = 4'd8;

  localparam logic [2:0] S3_ADDR_RS0    = 3'd0;
  localparam logic [2:0] S3_ADDR_RI     = 3'd1;
  localparam logic [2:0] S3_ADDR_DIRECT = 3'd2;
  localparam logic [2:0] S3_ADDR_BITM   = 3'd3;
  localparam logic [2:0] S3_ADDR_SP     = 3'd4;
  localparam logic [2:0] S3_ADDR_DPTR   = 3'd5;

  localparam logic [3:0] S5_ADDR_RS0    = 4'd0;
  localparam logic [3:0] S5_ADDR_RI     = 4'd1;
  localparam logic [3:0] S5_ADDR_DIRECT = 4'd2;
  localparam logic [3:0] S5_ADDR_S3B    = 4'd3;
  localparam logic [3:0] S5_ADDR_BITM0  = 4'd4;
  localparam logic [3:0] S5_ADDR_SP     = 4'd5;
  localparam logic [3:0] S5_ADDR_DPTR   = 4'd6;

  localparam logic [3:0] S5_WR_ACC = 4'd0;
  localparam logic [3:0] S5_WR_BX  = 4'd1;
  localparam logic [3:0] S5_WR_S3B = 4'd2;
  localparam logic [3:0] S5_WR_SX0 = 4'd3;
  localparam logic [3:0] S5_WR_SX1 = 4'd4;
  localparam logic [3:0] S5_WR_PCL = 4'd5;
  localparam logic [3:0] S5_WR_PCH = 4'd6;
  localparam logic [3:0] S5_WR_PSW = 4'd7;
  localparam logic [3:0] S5_WR_S2B = 4'd8;

  typedef enum logic [0:0] {
    S2_IDLE   = 1'b0,
    S2_ADD_HI = 1'b1
  } s2_state_t;

  function automatic logic [7:0] rn_addr(input logic [1:0] bank, input logic [2:0] rn);
    return {3'b000, bank, rn};
  endfunction

  function automatic logic [7:0] ri_addr(input logic [1:0] bank, input logic ri);
    return {3'b000, bank, 2'b00, ri};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc8051_bitaddr_dec.sv
// mc8051_bitaddr_dec: bit address to byte address plus bit index.
// Below 0x80 the bit lives in the 0x20-0x2F RAM area; above it in a bit-addressable SFR.
`default_nettype none
module mc8051_bitaddr_dec #(
  parameter int ADDR_W = 16
) (
  input  logic [7:0]        bit_addr,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [2:0]        bit_idx
);

  logic [7:0] byte8;

  always_comb begin
    if (bit_addr[7]) byte8 = {bit_addr[7:3], 3'b000};
    else             byte8 = {4'h2, bit_addr[6:3]};
  end

  assign byte_addr = ADDR_W'(byte8);
  assign bit_idx   = bit_addr[2:0];

endmodule
`default_nettype wire

// File: rtl/mc8051_mux_pipe.sv
// mc8051_mux_pipe: registered operand/address/write-data mux with valid pulses,
// split indexed adder on S2, undefined-select detection and global stall.
`default_nettype none
module mc8051_mux_pipe
  import mc8051_mux_pipe_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int ADD_SPLIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_alu_en,
  input  logic              i_s2_en,
  input  logic              i_s3_en,
  input  logic              i_s5_en,
  input  logic [2:0]        i_alu_in0_sel,
  input  logic [2:0]        i_alu_in1_sel,
  input  logic [3:0]        i_s2_mem_addr_sel,
  input  logic [2:0]        i_s3_mem_addr_sel,
  input  logic [3:0]        i_s5_mem_addr_sel,
  input  logic [3:0]        i_mem_wdata_sel,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_bx,
  input  logic [DATA_W-1:0] i_psw,
  input  logic [DATA_W-1:0] i_sp,
  input  logic [DATA_W-1:0] i_sx_0,
  input  logic [DATA_W-1:0] i_sx_1,
  input  logic [DATA_W-1:0] i_s1_instr_buffer,
  input  logic [DATA_W-1:0] i_s2_data_buffer,
  input  logic [DATA_W-1:0] i_s3_data_buffer,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_dptr,
  output logic [DATA_W-1:0] o_alu_in0,
  output logic [DATA_W-1:0] o_alu_in1,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [ADDR_W-1:0] o_s2_mem_addr,
  output logic [ADDR_W-1:0] o_s3_mem_addr,
  output logic [ADDR_W-1:0] o_s5_mem_addr,
  output logic [2:0]        o_bit_idx,
  output logic              o_alu_vld,
  output logic              o_s2_vld,
  output logic              o_s3_vld,
  output logic              o_s5_vld,
  output logic              o_busy,
  output logic              o_sel_err
);

  localparam int HI_W  = ADDR_W - DATA_W;
  localparam bit SPLIT = (ADD_SPLIT != 0);

  logic [ADDR_W-1:0] rn_a, ri_a;
  logic [ADDR_W-1:0] bit_byte [3];
  logic [2:0]        bit_pos  [3];

  assign rn_a = ADDR_W'(rn_addr(i_psw[4:3], i_s1_instr_buffer[2:0]));
  assign ri_a = ADDR_W'(ri_addr(i_psw[4:3], i_s1_instr_buffer[0]));

  // One decoder per BITM-capable port: 0 = S2, 1 = S3, 2 = S5.
  for (genvar g = 0; g < 3; g++) begin : g_bitdec
    mc8051_bitaddr_dec #(.ADDR_W(ADDR_W)) u_dec (
      .bit_addr  (i_s2_data_buffer[7:0]),
      .byte_addr (bit_byte[g]),
      .bit_idx   (bit_pos[g])
    );
  end

  logic [DATA_W-1:0] alu0_d, alu1_d, wdata_d;
  logic [ADDR_W-1:0] s2_d, s2_base, s3_d, s5_d;
  logic              alu_bad, s2_bad, s3_bad, s5_bad, s2_indexed;
  logic [DATA_W:0]   lo_sum;

  always_comb begin
    alu0_d = '0; alu1_d = '0; alu_bad = 1'b0;
    case (i_alu_in0_sel)
      ALU_I0_ACC:   alu0_d = i_acc;
      ALU_I0_BX:    alu0_d = i_bx;
      ALU_I0_INSTR: alu0_d = i_s1_instr_buffer;
      ALU_I0_S2B:   alu0_d = i_s2_data_buffer;
      ALU_I0_S3B:   alu0_d = i_s3_data_buffer;
      ALU_I0_SX0:   alu0_d = i_sx_0;
      ALU_I0_PSW:   alu0_d = i_psw;
      default:      alu_bad = 1'b1;
    endcase
    case (i_alu_in1_sel)
      ALU_I1_P1:   alu1_d = DATA_W'(1);
      ALU_I1_M1:   alu1_d = '1;
      ALU_I1_ZERO: alu1_d = '0;
      ALU_I1_BX:   alu1_d = i_bx;
      ALU_I1_SX1:  alu1_d = i_sx_1;
      ALU_I1_S2B:  alu1_d = i_s2_data_buffer;
      ALU_I1_S3B:  alu1_d = i_s3_data_buffer;
      default:     alu_bad = 1'b1;
    endcase
  end

  always_comb begin
    s2_d = '0; s2_base = '0; s2_bad = 1'b0; s2_indexed = 1'b0;
    case (i_s2_mem_addr_sel)
      S2_ADDR_RS0:    s2_d = rn_a;
      S2_ADDR_RI:     s2_d = ri_a;
      S2_ADDR_DIRECT: s2_d = ADDR_W'(i_s1_instr_buffer);
      S2_ADDR_BITM:   s2_d = bit_byte[0];
      S2_ADDR_SP:     s2_d = ADDR_W'(i_sp);
      S2_ADDR_DPTR:   s2_d = i_dptr;
      S2_ADDR_PC:     s2_d = i_pc;
      S2_ADDR_DPTRPA: begin s2_base = i_dptr; s2_indexed = 1'b1; end
      S2_ADDR_PCPA:   begin s2_base = i_pc;   s2_indexed = 1'b1; end
      default:        s2_bad = 1'b1;
    endcase
    if (s2_indexed) s2_d = s2_base + ADDR_W'(i_acc);
    lo_sum = {1'b0, s2_base[DATA_W-1:0]} + {1'b0, i_acc};
  end

  always_comb begin
    s3_d = '0; s3_bad = 1'b0;
    case (i_s3_mem_addr_sel)
      S3_ADDR_RS0:    s3_d = rn_a;
      S3_ADDR_RI:     s3_d = ri_a;
      S3_ADDR_DIRECT: s3_d = ADDR_W'(i_s2_data_buffer);
      S3_ADDR_BITM:   s3_d = bit_byte[1];
      S3_ADDR_SP:     s3_d = ADDR_W'(i_sp);
      S3_ADDR_DPTR:   s3_d = i_dptr;
      default:        s3_bad = 1'b1;
    endcase
  end

  always_comb begin
    s5_d = '0; wdata_d = '0; s5_bad = 1'b0;
    case (i_s5_mem_addr_sel)
      S5_ADDR_RS0:    s5_d = rn_a;
      S5_ADDR_RI:     s5_d = ri_a;
      S5_ADDR_DIRECT: s5_d = ADDR_W'(i_s2_data_buffer);
      S5_ADDR_S3B:    s5_d = ADDR_W'(i_s3_data_buffer);
      S5_ADDR_BITM0:  s5_d = bit_byte[2];
      S5_ADDR_SP:     s5_d = ADDR_W'(i_sp);
      S5_ADDR_DPTR:   s5_d = i_dptr;
      default:        s5_bad = 1'b1;
    endcase
    case (i_mem_wdata_sel)
      S5_WR_ACC: wdata_d = i_acc;
      S5_WR_BX:  wdata_d = i_bx;
      S5_WR_S3B: wdata_d = i_s3_data_buffer;
      S5_WR_SX0: wdata_d = i_sx_0;
      S5_WR_SX1: wdata_d = i_sx_1;
      S5_WR_PCL: wdata_d = i_pc[DATA_W-1:0];
      S5_WR_PCH: wdata_d = i_pc[2*DATA_W-1:DATA_W];
      S5_WR_PSW: wdata_d = i_psw;
      S5_WR_S2B: wdata_d = i_s2_data_buffer;
      default:   s5_bad = 1'b1;
    endcase
  end

  s2_state_t s2_state, s2_nxt;
  logic      s2_idle, take_alu, take_s2, take_s3, take_s5, s2_split, err_d;

  assign s2_idle  = (s2_state == S2_IDLE);
  assign take_alu = i_alu_en & ~alu_bad;
  assign take_s2  = i_s2_en & s2_idle & ~s2_bad;
  assign take_s3  = i_s3_en & ~s3_bad;
  assign take_s5  = i_s5_en & ~s5_bad;
  assign s2_split = take_s2 & s2_indexed & SPLIT;
  // S2 requests arriving while busy are dropped, so they cannot flag an error either.
  assign err_d    = (i_alu_en & alu_bad) | (i_s2_en & s2_idle & s2_bad) |
                    (i_s3_en & s3_bad) | (i_s5_en & s5_bad);

  always_comb begin
    s2_nxt = s2_state;
    case (s2_state)
      S2_IDLE:   if (s2_split) s2_nxt = S2_ADD_HI;
      S2_ADD_HI: s2_nxt = S2_IDLE;
    endcase
  end

  logic [DATA_W-1:0] alu_in0, alu_in1, mem_wdata, add_lo;
  logic [ADDR_W-1:0] s2_addr, s3_addr, s5_addr;
  logic [HI_W-1:0]   add_hi;
  logic [2:0]        bit_idx;
  logic              alu_vld, s2_vld, s3_vld, s5_vld, sel_err, add_c;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_state <= S2_IDLE;
      alu_in0 <= '0; alu_in1 <= '0; mem_wdata <= '0;
      s2_addr <= '0; s3_addr <= '0; s5_addr <= '0;
      add_lo  <= '0; add_hi  <= '0; add_c   <= 1'b0; bit_idx <= '0;
      alu_vld <= 1'b0; s2_vld <= 1'b0; s3_vld <= 1'b0; s5_vld <= 1'b0;
      sel_err <= 1'b0;
    end else if (!i_stall) begin
      s2_state <= s2_nxt;
      alu_vld  <= take_alu;
      s3_vld   <= take_s3;
      s5_vld   <= take_s5;
      s2_vld   <= 1'b0;
      sel_err  <= err_d;
      if (take_alu) begin
        alu_in0 <= alu0_d;
        alu_in1 <= alu1_d;
      end
      if (s2_state == S2_ADD_HI) begin
        s2_addr <= {add_hi + HI_W'(add_c), add_lo};
        s2_vld  <= 1'b1;
      end else if (s2_split) begin
        add_lo <= lo_sum[DATA_W-1:0];
        add_c  <= lo_sum[DATA_W];
        add_hi <= s2_base[ADDR_W-1:DATA_W];
      end else if (take_s2) begin
        s2_addr <= s2_d;
        s2_vld  <= 1'b1;
      end
      if (take_s3) s3_addr <= s3_d;
      if (take_s5) begin
        s5_addr   <= s5_d;
        mem_wdata <= wdata_d;
      end
      if (take_s5 && i_s5_mem_addr_sel == S5_ADDR_BITM0)     bit_idx <= bit_pos[2];
      else if (take_s3 && i_s3_mem_addr_sel == S3_ADDR_BITM) bit_idx <= bit_pos[1];
      else if (take_s2 && i_s2_mem_addr_sel == S2_ADDR_BITM) bit_idx <= bit_pos[0];
    end
  end

  assign o_alu_in0     = alu_in0;
  assign o_alu_in1     = alu_in1;
  assign o_mem_wdata   = mem_wdata;
  assign o_s2_mem_addr = s2_addr;
  assign o_s3_mem_addr = s3_addr;
  assign o_s5_mem_addr = s5_addr;
  assign o_bit_idx     = bit_idx;
  assign o_alu_vld     = alu_vld & ~i_stall;
  assign o_s2_vld      = s2_vld & ~i_stall;
  assign o_s3_vld      = s3_vld & ~i_stall;
  assign o_s5_vld      = s5_vld & ~i_stall;
  assign o_sel_err     = sel_err & ~i_stall;
  assign o_busy        = (s2_state == S2_ADD_HI);

endmodule
`default_nettype wire

// File: tb/tb_mc8051_mux_pipe.sv
// tb_mc8051_mux_pipe: scoreboard bench for the registered mux; expected results are
// queued per port when stimulus is driven and compared when each valid pulse appears.
`default_nettype none
module tb_mc8051_mux_pipe;
  import mc8051_mux_pipe_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n, stall, alu_en, s2_en, s3_en, s5_en;
  logic [2:0] alu_in0_sel, alu_in1_sel, s3_sel;
  logic [3:0] s2_sel, s5_sel, wdata_sel;
  logic [DATA_W-1:0] acc, bx, psw, sp, sx_0, sx_1, s1_instr, s2_buf, s3_buf;
  logic [ADDR_W-1:0] pc, dptr;
  logic [DATA_W-1:0] alu_in0, alu_in1, mem_wdata;
  logic [ADDR_W-1:0] s2_addr, s3_addr, s5_addr;
  logic [2:0] bit_idx;
  logic alu_vld, s2_vld, s3_vld, s5_vld, busy, sel_err;

  mc8051_mux_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADD_SPLIT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_alu_en(alu_en), .i_s2_en(s2_en), .i_s3_en(s3_en), .i_s5_en(s5_en),
    .i_alu_in0_sel(alu_in0_sel), .i_alu_in1_sel(alu_in1_sel),
    .i_s2_mem_addr_sel(s2_sel), .i_s5_mem_addr_sel(s5_sel), .i_mem_wdata_sel(wdata_sel),
    .i_s3_mem_addr_sel(s3_sel),
    .i_acc(acc), .i_bx(bx), .i_psw(psw), .i_sp(sp), .i_sx_0(sx_0), .i_sx_1(sx_1),
    .i_s1_instr_buffer(s1_instr), .i_s2_data_buffer(s2_buf), .i_s3_data_buffer(s3_buf),
    .i_pc(pc), .i_dptr(dptr),
    .o_alu_in0(alu_in0), .o_alu_in1(alu_in1), .o_mem_wdata(mem_wdata),
    .o_s2_mem_addr(s2_addr), .o_s3_mem_addr(s3_addr), .o_s5_mem_addr(s5_addr),
    .o_bit_idx(bit_idx),
    .o_alu_vld(alu_vld), .o_s2_vld(s2_vld), .o_s3_vld(s3_vld), .o_s5_vld(s5_vld),
    .o_busy(busy), .o_sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] q_alu[$], q_s2[$], q_s3[$], q_s5[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_en();
    alu_en = 1'b0; s2_en = 1'b0; s3_en = 1'b0; s5_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (alu_vld === 1'b1) begin
      if (q_alu.size() == 0) check_val("alu_spurious_vld", 32'd1, 32'd0);
      else check_val("alu_out", {16'h0, alu_in0, alu_in1}, q_alu.pop_front());
    end
    if (s2_vld === 1'b1) begin
      if (q_s2.size() == 0) check_val("s2_spurious_vld", 32'd1, 32'd0);
      else check_val("s2_addr", {16'h0, s2_addr}, q_s2.pop_front());
    end
    if (s3_vld === 1'b1) begin
      if (q_s3.size() == 0) check_val("s3_spurious_vld", 32'd1, 32'd0);
      else check_val("s3_addr", {16'h0, s3_addr}, q_s3.pop_front());
    end
    if (s5_vld === 1'b1) begin
      if (q_s5.size() == 0) check_val("s5_spurious_vld", 32'd1, 32'd0);
      else check_val("s5_addr_wdata", {8'h0, s5_addr, mem_wdata}, q_s5.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; drop_en();
    alu_in0_sel = ALU_I0_ACC; alu_in1_sel = ALU_I1_P1;
    s2_sel = S2_ADDR_RS0; s3_sel = S3_ADDR_RS0; s5_sel = S5_ADDR_RS0; wdata_sel = S5_WR_ACC;
    acc = '0; bx = '0; psw = '0; sp = '0; sx_0 = '0; sx_1 = '0;
    s1_instr = '0; s2_buf = '0; s3_buf = '0; pc = '0; dptr = '0;

    repeat (2) step();
    check_val("rst_alu_in0", 32'(alu_in0), 32'h0);
    check_val("rst_s2_addr", 32'(s2_addr), 32'h0);
    check_val("rst_s5_wdata", {8'h0, s5_addr, mem_wdata}, 32'h0);
    check_val("rst_flags", {26'h0, alu_vld, s2_vld, s3_vld, s5_vld, busy, sel_err}, 32'h0);
    rst_n = 1'b1;
    step();

    // Rn and @Ri address generation
    psw = 8'h18; s1_instr = 8'h0D; s2_sel = S2_ADDR_RS0; s2_en = 1'b1;
    q_s2.push_back(32'h001D);
    step(); drop_en();
    check_val("rn_vld_latency", 32'(s2_vld), 32'd1);
    psw = 8'h08; s1_instr = 8'h07; s3_sel = S3_ADDR_RI; s3_en = 1'b1;
    q_s3.push_back(32'h0009);
    step(); drop_en();
    step();

    // @A+DPTR with carry into the high byte
    dptr = 16'h12FF; acc = 8'h02; s2_sel = S2_ADDR_DPTRPA; s2_en = 1'b1;
    q_s2.push_back(32'h1301);
    step(); drop_en();
    check_val("split_busy", 32'(busy), 32'd1);
    check_val("split_no_early_vld", 32'(s2_vld), 32'd0);
    step();
    check_val("split_done_busy", 32'(busy), 32'd0);
    check_val("split_done_vld", 32'(s2_vld), 32'd1);
    step();

    // Stall held across ADD_HI; a stray ALU enable during stall must be ignored
    pc = 16'h10F0; acc = 8'h20; s2_sel = S2_ADDR_PCPA; s2_en = 1'b1;
    q_s2.push_back(32'h1110);
    step(); drop_en();
    stall = 1'b1; alu_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_busy", 32'(busy), 32'd1);
      check_val("stall_addr_hold", 32'(s2_addr), 32'h1301);
      check_val("stall_vld", {30'h0, s2_vld, alu_vld}, 32'h0);
    end
    alu_en = 1'b0; stall = 1'b0;
    step();
    check_val("stall_release_vld", {30'h0, s2_vld, busy}, 32'h2);
    step();

    // Address wrap modulo 2^ADDR_W
    dptr = 16'hFFFF; acc = 8'h01; s2_sel = S2_ADDR_DPTRPA; s2_en = 1'b1;
    q_s2.push_back(32'h0000);
    step(); drop_en();
    step();
    check_val("wrap_vld", 32'(s2_vld), 32'd1);
    step();

    // Bit address decode on S5 (RAM area, then SFR area)
    s2_buf = 8'h47; s5_sel = S5_ADDR_BITM0; wdata_sel = S5_WR_ACC; s5_en = 1'b1;
    q_s5.push_back({8'h0, 16'h0028, 8'h01});
    step(); drop_en();
    check_val("bitidx_ram", 32'(bit_idx), 32'd7);
    s2_buf = 8'hE3; s5_en = 1'b1;
    q_s5.push_back({8'h0, 16'h00E0, 8'h01});
    step(); drop_en();
    check_val("bitidx_sfr", 32'(bit_idx), 32'd3);

    // ALU constant all-ones with BX operand
    bx = 8'h3C; alu_in0_sel = ALU_I0_BX; alu_in1_sel = ALU_I1_M1; alu_en = 1'b1;
    q_alu.push_back({16'h0, 8'h3C, 8'hFF});
    step(); drop_en();

    // Simultaneous ALU and S5 captures
    acc = 8'h5A; sp = 8'h07; pc = 16'hAB12;
    alu_in0_sel = ALU_I0_ACC; alu_in1_sel = ALU_I1_P1; alu_en = 1'b1;
    s5_sel = S5_ADDR_SP; wdata_sel = S5_WR_PCH; s5_en = 1'b1;
    q_alu.push_back({16'h0, 8'h5A, 8'h01});
    q_s5.push_back({8'h0, 16'h0007, 8'hAB});
    step(); drop_en();
    check_val("dual_vld", {30'h0, alu_vld, s5_vld}, 32'h3);
    step();

    // Undefined S3 select keeps the old address and pulses sel_err once
    s2_buf = 8'h33; s3_sel = S3_ADDR_DIRECT; s3_en = 1'b1;
    q_s3.push_back(32'h0033);
    step(); drop_en();
    s3_sel = 3'd7; s3_en = 1'b1;
    step(); drop_en();
    check_val("undef_sel_err", 32'(sel_err), 32'd1);
    check_val("undef_s3_vld", 32'(s3_vld), 32'd0);
    check_val("undef_s3_hold", 32'(s3_addr), 32'h0033);
    step();
    check_val("sel_err_pulse", 32'(sel_err), 32'd0);

    // Reset during ADD_HI abandons the split add
    pc = 16'h2000; acc = 8'hFF; s2_sel = S2_ADDR_PCPA; s2_en = 1'b1;
    step(); drop_en();
    check_val("rst_mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    check_val("rst_mid_flags", {26'h0, alu_vld, s2_vld, s3_vld, s5_vld, busy, sel_err}, 32'h0);
    check_val("rst_mid_addr", {s2_addr, s3_addr}, 32'h0);
    check_val("rst_mid_data", {5'h0, bit_idx, alu_in0, alu_in1, mem_wdata}, 32'h0);
    rst_n = 1'b1;
    step();
    check_val("rst_mid_no_vld", 32'(s2_vld), 32'd0);
    step();

    check_val("alu_pending", 32'(q_alu.size()), 32'd0);
    check_val("s2_pending", 32'(q_s2.size()), 32'd0);
    check_val("s3_pending", 32'(q_s3.size()), 32'd0);
    check_val("s5_pending", 32'(q_s5.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
